keccak_pad_ctrl: RTL

KECCAK_PAD_CTRL -- requirements
Module: keccak_pad_ctrl

---
 rtl/keccak_pad_ctrl_pkg.sv | 15 +
 rtl/keccak_pad_ctrl_padder1ky.sv | 22 ++
 rtl/keccak_pad_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/keccak_pad_ctrl_pkg.sv
// Shared Keccak constants: default rate, padding bytes and pad-controller state encodings.
package keccak_pad_ctrl_pkg;

  typedef logic [63:0] word_t;

  localparam int RATE_WORDS_DEFAULT = 17;

  localparam logic [7:0] DOMAIN_BYTE = 8'h06;
  localparam logic [7:0] FINAL_BYTE  = 8'h80;

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/keccak_pad_ctrl_padder1ky.sv
// Pads a partial final word: keeps the top byte_num bytes, appends the domain byte, zeroes the rest.
module padder1ky
  import keccak_pad_ctrl_pkg::*;
(
  input  logic [63:0] in_i,
  input  logic [2:0]  byte_num_i,
  output word_t       out_o
);

  // NOTE: out_o gets a full default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    out_o = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(byte_num_i)) begin
        out_o[63-8*i -: 8] = in_i[63-8*i -: 8];
      end else if (i == int'(byte_num_i)) begin
        out_o[63-8*i -: 8] = DOMAIN_BYTE;
      end
    end
  end

endmodule

// File: rtl/keccak_pad_ctrl.sv
// Assembles 64-bit message words into one rate block, applying SHA-3 padding to the final word.
module keccak_pad_ctrl
  import keccak_pad_ctrl_pkg::*;
#(
  parameter int RATE_WORDS = RATE_WORDS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [63:0]             in,
  input  logic [2:0]              byte_num,
  input  logic                    in_valid,
  input  logic                    is_last,
  output logic                    in_ready,
  output logic [64*RATE_WORDS-1:0] out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int OUT_W = 64 * RATE_WORDS;
  localparam int CNT_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATE_WORDS - 1);
  localparam word_t FINAL_WORD = {56'd0, FINAL_BYTE};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             last_q, last_d;
  word_t            pad_word;
  word_t            shift_word;
  logic             completes;

  padder1ky u_padder (
    .in_i       (in),
    .byte_num_i (byte_num),
    .out_o      (pad_word)
  );

  assign completes = (cnt_q == LAST_CNT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    last_d     = last_q;
    shift_word = '0;
    case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          shift_word = is_last ? pad_word : in;
          if (completes && is_last) begin
            shift_word = shift_word | FINAL_WORD;
          end
          // Truncating the concatenation drops the oldest word off the top.
          out_d = OUT_W'({out_q, shift_word});
          if (completes) begin
            state_d = ST_FULL;
            last_d  = is_last;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (is_last) begin
              state_d = ST_FILL;
            end
          end
        end
      end
      ST_FILL: begin
        shift_word = completes ? FINAL_WORD : '0;
        out_d      = OUT_W'({out_q, shift_word});
        if (completes) begin
          state_d = ST_FULL;
          last_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
          last_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_ACCUM;
        last_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the pre-edge values.
  // The block register is reset too, because a discarded partial block must never be visible on out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ACCUM;
      cnt_q   <= '0;
      out_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      last_q  <= last_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_FULL);
  assign out       = out_q;
  assign out_last  = last_q;

endmodule
